ip_uart_rx: RTL and testbench

- Z80 I/O-mapped 8N1 UART receiver. It is the receive-side counterpart of the design's UART transmitter.
- Samples the asynchronous serial input and deframes bytes into a small FIFO.
- Exposes a data port and a status port on the CPU I/O bus. The CPU reads these through the same iorq_n/rd_n/a/q/q_en read-mux scheme used by the other peripherals.

---
 rtl/ip_uart_rx.sv | 170 +++++++++++++++++
 tb/tb_ip_uart_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ip_uart_rx.sv
// Z80 I/O-mapped 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling deframer, small receive FIFO.
// Data port at io_address pops the FIFO head; the status port at io_address+1 returns {frame_err, overrun, full, ready} and clears the error flags.
module ip_uart_rx #(
    parameter int         clk_freq   = 43200000,
    parameter int         uart_freq  = 115200,
    parameter logic [7:0] io_address = 8'h10,
    parameter int         fifo_depth = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic [7:0] a,
    output logic [7:0] q,
    output logic       q_en,
    input  logic       uart_rx
);

    localparam int BIT  = clk_freq / uart_freq;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);
    localparam int AW   = $clog2(fifo_depth);
    localparam int PW   = AW + 1;
    localparam logic [CW-1:0] BIT_M1    = CW'(BIT - 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
    localparam logic [7:0]    STAT_ADDR = io_address + 8'd1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            rx_s_q, rx_s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [fifo_depth];
    logic [7:0]      mem_d [fifo_depth];
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic            rd_hit_dly_q, rd_hit_dly_d;
    logic            q_en_q, q_en_d;
    logic [7:0]      q_q, q_d;

    logic push, ferr_evt, ovr_evt;
    logic rd_hit, rd_start, pop, stat_rd, empty, full;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        sync1_d   = uart_rx;
        rx_s_d    = sync1_q;
        push      = 1'b0;
        ferr_evt  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s_q) begin
                    state_d   = S_DATA;
                    cnt_d     = BIT_M1;
                    bit_idx_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = BIT_M1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                    if (rx_s_q) push = 1'b1;
                    else        ferr_evt = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_hit       = !iorq_n && !rd_n && (a == io_address || a == STAT_ADDR);
        rd_start     = rd_hit && !rd_hit_dly_q;
        rd_hit_dly_d = rd_hit;
        q_en_d       = rd_hit;
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop          = rd_start && (a == io_address) && !empty;
        stat_rd      = rd_start && (a == STAT_ADDR);
        q_d          = q_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        mem_d        = mem_q;
        ovr_evt      = 1'b0;
        if (rd_start) begin
            if (a == io_address) q_d = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
            else                 q_d = {4'b0, frame_err_q, overrun_q, full, !empty};
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
        if (push) begin
            if (!full || pop) begin
                mem_d[wr_ptr_q[AW-1:0]] = shift_q;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                ovr_evt = 1'b1;
            end
        end
        overrun_d   = (overrun_q && !stat_rd) || ovr_evt;
        frame_err_d = (frame_err_q && !stat_rd) || ferr_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_hit_dly_q <= 1'b0;
            q_en_q       <= 1'b0;
            q_q          <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            rd_hit_dly_q <= rd_hit_dly_d;
            q_en_q       <= q_en_d;
            q_q          <= q_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign q    = q_q;
    assign q_en = q_en_q;

endmodule

// File: tb/tb_ip_uart_rx.sv
// Directed and randomized bench for ip_uart_rx against a byte-level queue model of the receiver.
module tb_ip_uart_rx;
    localparam int BIT  = 375;
    localparam int HALF = 187;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iorq_n = 1'b1;
    logic       rd_n = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] q;
    logic       q_en;
    logic       uart_rx = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_q [$];
    logic       model_ovr = 1'b0;
    logic       model_fe = 1'b0;
    logic [7:0] last_q = 8'h00;

    ip_uart_rx dut (
        .clk     (clk),
        .reset   (reset),
        .iorq_n  (iorq_n),
        .rd_n    (rd_n),
        .a       (a),
        .q       (q),
        .q_en    (q_en),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic good);
        if (!good)                        model_fe = 1'b1;
        else if (model_q.size() < DEPTH)  model_q.push_back(b);
        else                              model_ovr = 1'b1;
    endfunction

    function automatic logic [7:0] model_status();
        logic [7:0] r;
        r = {4'b0, model_fe, model_ovr, model_q.size() == DEPTH, model_q.size() != 0};
        model_fe  = 1'b0;
        model_ovr = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] model_data();
        if (model_q.size() == 0) return 8'h00;
        return model_q.pop_front();
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic good);
        uart_rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clks(BIT);
        end
        if (good) begin
            uart_rx = 1'b1;
            wait_clks(BIT);
        end else begin
            // Low long enough to cover the mid-bit sample, then released before any false start can latch.
            uart_rx = 1'b0;
            wait_clks(HALF + 50);
            uart_rx = 1'b1;
            wait_clks(BIT - HALF - 50);
        end
        wait_clks(50);
        model_frame(b, good);
    endtask

    task automatic bus_read(input string tag, input logic [7:0] addr, input int hold, input logic [7:0] exp);
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        a      = addr;
        @(negedge clk);
        chk({tag, "_qen_pre"}, {7'b0, q_en}, 8'h00);
        wait_clks(1);
        chk({tag, "_qen"}, {7'b0, q_en}, 8'h01);
        chk(tag, q, exp);
        if (hold > 1) begin
            wait_clks(hold - 1);
            chk({tag, "_hold"}, q, exp);
            chk({tag, "_qen_hold"}, {7'b0, q_en}, 8'h01);
        end
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        a      = 8'h00;
        wait_clks(1);
        chk({tag, "_qen_off"}, {7'b0, q_en}, 8'h00);
        chk({tag, "_q_kept"}, q, exp);
        last_q = exp;
        wait_clks(2);
    endtask

    initial begin
        logic [7:0] b1, b2, rb;
        logic       good;

        reset = 1'b1;
        wait_clks(3);
        chk("rst_q", q, 8'h00);
        chk("rst_qen", {7'b0, q_en}, 8'h00);
        reset = 1'b0;
        wait_clks(5);

        send_byte(8'h55, 1'b1);
        bus_read("st_55", 8'h11, 1, model_status());
        bus_read("dat_55", 8'h10, 1, model_data());
        bus_read("st_55_empty", 8'h11, 1, model_status());

        send_byte(8'hA3, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h7E, 1'b1);
        bus_read("st_ovr", 8'h11, 1, model_status());
        bus_read("st_ovr_clr", 8'h11, 1, model_status());
        for (int i = 0; i < DEPTH; i++) bus_read($sformatf("dat_full%0d", i), 8'h10, 1, model_data());
        bus_read("dat_empty", 8'h10, 1, model_data());

        uart_rx = 1'b0;
        wait_clks(100);
        uart_rx = 1'b1;
        wait_clks(600);
        bus_read("st_glitch", 8'h11, 1, model_status());

        iorq_n = 1'b0;
        rd_n   = 1'b0;
        a      = 8'h12;
        wait_clks(3);
        chk("other_qen", {7'b0, q_en}, 8'h00);
        chk("other_q", q, last_q);
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        a      = 8'h00;
        wait_clks(2);

        send_byte(8'h3C, 1'b0);
        bus_read("st_ferr", 8'h11, 1, model_status());
        bus_read("st_ferr_clr", 8'h11, 1, model_status());

        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        bus_read("dat_long", 8'h10, 20, model_data());
        bus_read("st_after_long", 8'h11, 1, model_status());
        bus_read("dat_second", 8'h10, 1, model_data());

        uart_rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            uart_rx = b1[i];
            wait_clks(BIT);
        end
        uart_rx = 1'b1;
        reset   = 1'b1;
        iorq_n  = 1'b0;
        rd_n    = 1'b0;
        a       = 8'h11;
        wait_clks(4);
        chk("midrst_q", q, 8'h00);
        chk("midrst_qen", {7'b0, q_en}, 8'h00);
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        a      = 8'h00;
        reset  = 1'b0;
        model_q.delete();
        model_ovr = 1'b0;
        model_fe  = 1'b0;
        wait_clks(BIT);
        send_byte(8'h81, 1'b1);
        bus_read("st_81", 8'h11, 1, model_status());
        bus_read("dat_81", 8'h10, 1, model_data());
        bus_read("st_81_empty", 8'h11, 1, model_status());

        for (int k = 0; k < 3; k++) begin
            rb   = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            send_byte(rb, good);
        end
        bus_read("st_rand", 8'h11, 1, model_status());
        while (model_q.size() > 0) bus_read("dat_rand", 8'h10, 1, model_data());
        bus_read("st_rand_end", 8'h11, 1, model_status());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
